// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types, priority-mode constants and helpers for the Wishbone B3 arbiter
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Highest set bit wins; callers only ever pass a one-hot or all-zero vector.
  function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// rtl/wb_rr_picker.sv - combinational requester-to-winner encoder (round-robin or fixed priority)
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int MASTERS   = 3,
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic [MASTERS-1:0]         req,
  input  logic [$clog2(MASTERS)-1:0] last,
  output logic [$clog2(MASTERS)-1:0] win_idx,
  output logic                       win_valid
);

  localparam int IW = $clog2(MASTERS);

  logic [IW-1:0] cand;

  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    cand      = '0;
    if (PRIO_MODE == PRIO_FIXED) begin
      for (int i = MASTERS - 1; i >= 0; i--) begin
        if (req[i]) begin
          win_idx   = IW'(i);
          win_valid = 1'b1;
        end
      end
    end else begin
      // Walk from furthest to nearest so the slot right after `last` is the final override.
      for (int k = MASTERS; k >= 1; k--) begin
        cand = IW'((int'(last) + k) % MASTERS);
        if (req[cand]) begin
          win_idx   = cand;
          win_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_rr_b3.sv
// rtl/wb_arbiter_rr_b3.sv - Wishbone B3 multi-master arbiter with ownership FSM, watchdog abort and status
module wb_arbiter_rr_b3
  import wb_arb_pkg::*;
#(
  parameter int MASTERS   = 3,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MASTERS-1:0]      m_cyc,
  input  logic [MASTERS-1:0]      m_stb,
  input  logic [MASTERS-1:0]      m_we,
  input  logic [MASTERS*32-1:0]   m_adr,
  input  logic [MASTERS*32-1:0]   m_dat_m2s,
  input  logic [MASTERS*4-1:0]    m_sel,
  input  logic [MASTERS*3-1:0]    m_cti,
  input  logic [MASTERS*2-1:0]    m_bte,
  output logic [MASTERS*32-1:0]   m_dat_s2m,
  output logic [MASTERS-1:0]      m_ack,
  output logic [MASTERS-1:0]      m_err,
  output logic [MASTERS-1:0]      m_rty,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [31:0]             s_adr,
  output logic [31:0]             s_dat_m2s,
  output logic [3:0]              s_sel,
  output logic [2:0]              s_cti,
  output logic [1:0]              s_bte,
  input  logic [31:0]             s_dat_s2m,
  input  logic                    s_ack,
  input  logic                    s_err,
  input  logic                    s_rty,
  output logic [MASTERS-1:0]      grant,
  output logic                    timeout_evt
);

  localparam int IW = $clog2(MASTERS);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t         state_q, state_d;
  logic [MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]      last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      owner;
  logic [IW-1:0]      win_idx;
  logic               win_valid;
  logic               busy, own_cyc, own_stb, term;

  wb_rr_picker #(
    .MASTERS   (MASTERS),
    .PRIO_MODE (PRIO_MODE)
  ) u_picker (
    .req       (m_cyc),
    .last      (last_q),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  // The registered one-hot grant is the single source of truth for ownership.
  assign owner       = IW'(onehot2idx(16'(grant_q)));
  assign busy        = (state_q == BUSY);
  assign own_cyc     = m_cyc[owner];
  assign own_stb     = m_stb[owner];
  assign term        = s_ack | s_err | s_rty;
  assign grant       = grant_q;
  assign timeout_evt = (state_q == ABORT);

  always_comb begin
    s_cyc     = busy & own_cyc;
    s_stb     = busy & own_stb;
    s_we      = busy & m_we[owner];
    s_adr     = busy ? m_adr[owner*32 +: 32]     : 32'd0;
    s_dat_m2s = busy ? m_dat_m2s[owner*32 +: 32] : 32'd0;
    s_sel     = busy ? m_sel[owner*4 +: 4]       : 4'd0;
    s_cti     = busy ? m_cti[owner*3 +: 3]       : 3'd0;
    s_bte     = busy ? m_bte[owner*2 +: 2]       : 2'd0;
    for (int i = 0; i < MASTERS; i++) begin
      m_ack[i]            = busy && (owner == IW'(i)) && s_ack;
      m_rty[i]            = busy && (owner == IW'(i)) && s_rty;
      m_err[i]            = (owner == IW'(i)) && ((busy && s_err) || (state_q == ABORT));
      m_dat_s2m[i*32 +: 32] = (busy && (owner == IW'(i))) ? s_dat_s2m : 32'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d          = BUSY;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          last_d           = win_idx;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (own_stb && !term && (TIMEOUT != 0)) begin
          // A termination in the same cycle the limit is reached takes precedence.
          if (cnt_q == CW'(TIMEOUT)) state_d = ABORT;
          else                       cnt_d   = cnt_q + CW'(1);
        end
      end
      ABORT: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_rr_b3.sv
// tb/tb_wb_arbiter_rr_b3.sv - directed self-checking bench for wb_arbiter_rr_b3
module tb_wb_arbiter_rr_b3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  m_cyc, m_stb, m_we;
  logic [95:0] m_adr, m_dat_m2s;
  logic [11:0] m_sel;
  logic [8:0]  m_cti;
  logic [5:0]  m_bte;
  logic [31:0] s_dat_s2m;

  logic [95:0] m_dat_s2m;
  logic [2:0]  m_ack, m_err, m_rty, grant;
  logic        s_cyc, s_stb, s_we, timeout_evt;
  logic [31:0] s_adr, s_dat_m2s;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic        s_ack, s_err, s_rty;
  logic        auto_ack, ack_force;

  logic [95:0] fx_m_dat_s2m;
  logic [2:0]  fx_m_ack, fx_m_err, fx_m_rty, fx_grant;
  logic        fx_s_cyc, fx_s_stb, fx_s_we, fx_evt;
  logic [31:0] fx_s_adr, fx_s_dat_m2s;
  logic [3:0]  fx_s_sel;
  logic [2:0]  fx_s_cti;
  logic [1:0]  fx_s_bte;
  logic        fx_s_ack;

  assign s_ack    = auto_ack ? (s_cyc & s_stb) : ack_force;
  assign s_err    = 1'b0;
  assign s_rty    = 1'b0;
  assign fx_s_ack = fx_s_cyc & fx_s_stb;

  wb_arbiter_rr_b3 #(.MASTERS(3), .PRIO_MODE(0), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_m2s(m_dat_m2s),
    .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
    .m_dat_s2m(m_dat_s2m), .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_m2s(s_dat_m2s),
    .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_dat_s2m(s_dat_s2m), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
    .grant(grant), .timeout_evt(timeout_evt)
  );

  wb_arbiter_rr_b3 #(.MASTERS(3), .PRIO_MODE(1), .TIMEOUT(8)) dut_fx (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_m2s(m_dat_m2s),
    .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
    .m_dat_s2m(fx_m_dat_s2m), .m_ack(fx_m_ack), .m_err(fx_m_err), .m_rty(fx_m_rty),
    .s_cyc(fx_s_cyc), .s_stb(fx_s_stb), .s_we(fx_s_we), .s_adr(fx_s_adr), .s_dat_m2s(fx_s_dat_m2s),
    .s_sel(fx_s_sel), .s_cti(fx_s_cti), .s_bte(fx_s_bte),
    .s_dat_s2m(s_dat_s2m), .s_ack(fx_s_ack), .s_err(1'b0), .s_rty(1'b0),
    .grant(fx_grant), .timeout_evt(fx_evt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_masters();
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_m2s = '0;
    m_sel = '0; m_cti = '0; m_bte = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_masters();
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [2:0] rr_cyc   [11] = '{3'b111, 3'b111, 3'b110, 3'b111, 3'b111, 3'b101,
                                3'b101, 3'b101, 3'b001, 3'b001, 3'b001};
  logic [2:0] rr_grant [11] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010,
                                3'b000, 3'b100, 3'b100, 3'b000, 3'b001};
  logic [2:0] rr_ack   [11] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b010, 3'b000,
                                3'b000, 3'b100, 3'b000, 3'b000, 3'b001};

  logic [2:0] fx_cyc   [8] = '{3'b111, 3'b111, 3'b110, 3'b111, 3'b111, 3'b110, 3'b111, 3'b111};
  logic [2:0] fx_exp   [8] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 3'b001};

  logic       b_cyc0   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [2:0] b_cti0   [8] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b111, 3'b000, 3'b000, 3'b000};
  logic [2:0] b_grant  [8] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b100};
  logic [2:0] b_ack    [8] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b100};
  logic [2:0] b_scti   [8] = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b111, 3'b000, 3'b000, 3'b000};

  initial begin
    rst = 1'b1;
    auto_ack = 1'b1;
    ack_force = 1'b0;
    s_dat_s2m = 32'h1234_5678;
    clear_masters();
    tick();
    tick();
    #2;
    chk("rst_grant", grant, 3'b000);
    chk("rst_evt", timeout_evt, 1'b0);
    chk("rst_scyc", s_cyc, 1'b0);
    chk("rst_sstb", s_stb, 1'b0);
    chk("rst_ack", m_ack, 3'b000);
    chk("rst_err", m_err, 3'b000);

    // single master 1 write
    tick();
    rst = 1'b0;
    m_cyc = 3'b010; m_stb = 3'b010; m_we = 3'b010;
    m_adr[63:32] = 32'h0200_0010; m_dat_m2s[63:32] = 32'hDEAD_BEEF; m_sel[7:4] = 4'hF;
    #2;
    chk("t1_idle_grant", grant, 3'b000);
    chk("t1_idle_scyc", s_cyc, 1'b0);
    tick();
    #2;
    chk("t1_grant", grant, 3'b010);
    chk("t1_scyc", s_cyc, 1'b1);
    chk("t1_adr", s_adr, 32'h0200_0010);
    chk("t1_dat", s_dat_m2s, 32'hDEAD_BEEF);
    chk("t1_sel", s_sel, 4'hF);
    chk("t1_we", s_we, 1'b1);
    chk("t1_ack", m_ack, 3'b010);
    chk("t1_rdat_owner", m_dat_s2m[63:32], 32'h1234_5678);
    chk("t1_rdat_others", {m_dat_s2m[95:64], m_dat_s2m[31:0]}, 64'd0);
    tick();
    clear_masters();
    #2;
    chk("t1_drop_scyc", s_cyc, 1'b0);
    chk("t1_drop_ack", m_ack, 3'b000);
    tick();
    #2;
    chk("t1_release_grant", grant, 3'b000);

    // round-robin contention: single reads, master 0 re-requests
    do_reset();
    for (int i = 0; i < 11; i++) begin
      m_cyc = rr_cyc[i];
      m_stb = rr_cyc[i];
      #2;
      chk($sformatf("rr_grant_%0d", i), grant, rr_grant[i]);
      chk($sformatf("rr_ack_%0d", i), m_ack, rr_ack[i]);
      tick();
    end

    // fixed priority: master 0 keeps coming back and keeps winning
    do_reset();
    for (int i = 0; i < 8; i++) begin
      m_cyc = fx_cyc[i];
      m_stb = fx_cyc[i];
      #2;
      chk($sformatf("fx_grant_%0d", i), fx_grant, fx_exp[i]);
      tick();
    end

    // burst lock: master 0 4-beat burst while master 2 waits
    do_reset();
    for (int i = 0; i < 8; i++) begin
      m_cyc = {1'b1, 1'b0, b_cyc0[i]};
      m_stb = {1'b1, 1'b0, b_cyc0[i]};
      m_cti[2:0] = b_cti0[i];
      #2;
      chk($sformatf("burst_grant_%0d", i), grant, b_grant[i]);
      chk($sformatf("burst_ack_%0d", i), m_ack, b_ack[i]);
      chk($sformatf("burst_cti_%0d", i), s_cti, b_scti[i]);
      tick();
    end

    // watchdog: slave never acks, abort 9 cycles after stb reaches the slave
    do_reset();
    auto_ack = 1'b0;
    m_cyc = 3'b010;
    m_stb = 3'b010;
    #2;
    chk("wd_idle_grant", grant, 3'b000);
    for (int w = 1; w <= 9; w++) begin
      tick();
      #2;
      chk($sformatf("wd_evt_%0d", w), timeout_evt, 1'b0);
      chk($sformatf("wd_scyc_%0d", w), s_cyc, 1'b1);
    end
    tick();
    #2;
    chk("wd_abort_err", m_err, 3'b010);
    chk("wd_abort_evt", timeout_evt, 1'b1);
    chk("wd_abort_scyc", s_cyc, 1'b0);
    chk("wd_abort_sstb", s_stb, 1'b0);
    tick();
    #2;
    chk("wd_after_evt", timeout_evt, 1'b0);
    chk("wd_after_grant", grant, 3'b000);
    chk("wd_after_err", m_err, 3'b000);
    tick();
    #2;
    chk("wd_rearb_grant", grant, 3'b010);
    for (int w = 13; w <= 19; w++) tick();
    tick();
    ack_force = 1'b1;
    #2;
    chk("wd_late_ack", m_ack, 3'b010);
    chk("wd_late_evt", timeout_evt, 1'b0);
    tick();
    ack_force = 1'b0;
    #2;
    chk("wd_noabort_evt", timeout_evt, 1'b0);
    chk("wd_noabort_err", m_err, 3'b000);
    chk("wd_noabort_scyc", s_cyc, 1'b1);
    clear_masters();
    auto_ack = 1'b1;
    tick();

    // reset in the middle of a burst
    do_reset();
    m_cyc = 3'b001; m_stb = 3'b001; m_cti[2:0] = 3'b010;
    #2;
    chk("mr_idle_grant", grant, 3'b000);
    tick();
    #2;
    chk("mr_beat1_grant", grant, 3'b001);
    tick();
    rst = 1'b1;
    m_cyc = 3'b011; m_stb = 3'b011;
    #2;
    chk("mr_beat2_ack", m_ack, 3'b001);
    tick();
    rst = 1'b0;
    #2;
    chk("mr_rst_grant", grant, 3'b000);
    chk("mr_rst_scyc", s_cyc, 1'b0);
    chk("mr_rst_ack", m_ack, 3'b000);
    tick();
    #2;
    chk("mr_post_grant", grant, 3'b001);
    clear_masters();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
